lfsr5_checker: RTL and testbench



---
 rtl/lfsr5_pkg.sv | 19 +
 rtl/lfsr5_checker_if.sv | 24 ++
 rtl/lfsr5_predict.sv | 35 +++
 rtl/lfsr5_checker.sv | 133 +++++++++++++
 tb/tb_lfsr5_checker.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/lfsr5_pkg.sv
// Shared types, constants and the next-word function for the 5-bit status LFSR checker.
package lfsr5_pkg;

  localparam int unsigned LFSR_W = 5;
  localparam logic [LFSR_W-1:0] LOCKUP = 5'b11111;
  localparam logic [LFSR_W-1:0] SEED   = 5'b00001;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  // XNOR feedback of bits 4 and 2, shifted in at bit 0
  function automatic logic [LFSR_W-1:0] next_word(input logic [LFSR_W-1:0] w);
    return {w[3:0], ~(w[4] ^ w[2])};
  endfunction

endpackage

// File: rtl/lfsr5_checker_if.sv
// Status-word stream into the checker and lock/error reporting back out.
interface lfsr5_checker_if #(
  parameter int unsigned ERR_W = 8
);
  import lfsr5_pkg::*;

  logic              in_valid;
  logic [LFSR_W-1:0] in_word;
  logic              clear;
  logic              locked;
  logic              mismatch;
  logic [ERR_W-1:0]  err_count;

  modport master (
    output in_valid, in_word, clear,
    input  locked, mismatch, err_count
  );

  modport slave (
    input  in_valid, in_word, clear,
    output locked, mismatch, err_count
  );

endinterface

// File: rtl/lfsr5_predict.sv
// Prediction register: reseeds from a sampled word or advances along the sequence.
module lfsr5_predict
  import lfsr5_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_en_i,
  input  logic              adv_en_i,
  input  logic [LFSR_W-1:0] word_i,
  output logic [LFSR_W-1:0] predict_o
);

  logic [LFSR_W-1:0] predict_q;
  logic [LFSR_W-1:0] predict_d;

  always_comb begin
    predict_d = predict_q;
    if (seed_en_i) begin
      predict_d = next_word(word_i);
    end else if (adv_en_i) begin
      predict_d = next_word(predict_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      predict_q <= '0;
    end else begin
      predict_q <= predict_d;
    end
  end

  assign predict_o = predict_q;

endmodule

// File: rtl/lfsr5_checker.sv
// Locks onto the 5-bit status LFSR stream and counts deviations once locked.
// LFSR5_CHK_FLYWHEEL_EN: tolerate up to LOSS_COUNT-1 consecutive misses while locked.
module lfsr5_checker
  import lfsr5_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 3,
  parameter int unsigned ERR_W      = 8
) (
  input  logic            clk,
  input  logic            rst,
  lfsr5_checker_if.slave  chk_if
);

  localparam int unsigned RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MISS_W = $clog2(LOSS_COUNT + 1);
`ifdef LFSR5_CHK_FLYWHEEL_EN
  localparam bit FLYWHEEL = 1'b1;
`else
  localparam bit FLYWHEEL = 1'b0;
`endif

  chk_state_e        state_q;
  logic [RUN_W-1:0]  run_q;
  logic [MISS_W-1:0] miss_q;
  logic [ERR_W-1:0]  err_q;
  logic              locked_q;
  logic              mismatch_q;
  logic [LFSR_W-1:0] predict;

  logic word_ok_c;
  logic match_c;
  logic lock_hit_c;
  logic drop_c;
  logic seed_en_c;
  logic adv_en_c;
  logic err_inc_c;

  // Decode of the sampled word against the current prediction
  always_comb begin
    word_ok_c  = (chk_if.in_word != LOCKUP);
    match_c    = word_ok_c && (chk_if.in_word == predict);
    lock_hit_c = ((run_q + RUN_W'(1)) == RUN_W'(LOCK_COUNT));
    drop_c     = !FLYWHEEL || ((miss_q + MISS_W'(1)) == MISS_W'(LOSS_COUNT));
    seed_en_c  = 1'b0;
    adv_en_c   = 1'b0;
    err_inc_c  = 1'b0;
    if (chk_if.in_valid) begin
      unique case (state_q)
        SEARCH:  seed_en_c = word_ok_c;
        VERIFY: begin
          adv_en_c  = match_c;
          seed_en_c = !match_c && word_ok_c;
        end
        LOCKED: begin
          adv_en_c  = 1'b1;
          err_inc_c = !match_c;
        end
        default: ;
      endcase
    end
  end

  lfsr5_predict u_predict (
    .clk       (clk),
    .rst       (rst),
    .seed_en_i (seed_en_c),
    .adv_en_i  (adv_en_c),
    .word_i    (chk_if.in_word),
    .predict_o (predict)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SEARCH;
      run_q      <= '0;
      miss_q     <= '0;
      err_q      <= '0;
      locked_q   <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      mismatch_q <= 1'b0;
      if (chk_if.in_valid) begin
        unique case (state_q)
          SEARCH: begin
            if (word_ok_c) begin
              run_q   <= '0;
              state_q <= VERIFY;
            end
          end
          VERIFY: begin
            if (match_c) begin
              run_q <= run_q + RUN_W'(1);
              if (lock_hit_c) begin
                state_q  <= LOCKED;
                miss_q   <= '0;
                locked_q <= 1'b1;
              end
            end else if (word_ok_c) begin
              run_q <= '0;
            end else begin
              state_q <= SEARCH;
            end
          end
          LOCKED: begin
            if (match_c) begin
              miss_q <= '0;
            end else begin
              miss_q     <= miss_q + MISS_W'(1);
              mismatch_q <= 1'b1;
              if (drop_c) begin
                state_q  <= SEARCH;
                locked_q <= 1'b0;
              end
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
      // Clear wins over a same-cycle error; the count never wraps
      if (chk_if.clear) begin
        err_q <= '0;
      end else if (err_inc_c && (err_q != '1)) begin
        err_q <= err_q + ERR_W'(1);
      end
    end
  end

  assign chk_if.locked    = locked_q;
  assign chk_if.mismatch  = mismatch_q;
  assign chk_if.err_count = err_q;

endmodule

// File: tb/tb_lfsr5_checker.sv
// Randomized and directed check of lfsr5_checker against a behavioural model (two parameter sets).
module tb_lfsr5_checker;
  import lfsr5_pkg::*;

`ifdef LFSR5_CHK_FLYWHEEL_EN
  localparam bit FLY = 1'b1;
`else
  localparam bit FLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lfsr5_checker_if #(.ERR_W(8)) if_a ();
  lfsr5_checker_if #(.ERR_W(2)) if_b ();

  lfsr5_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .ERR_W(8)) u_dut_a (
    .clk (clk), .rst (rst), .chk_if (if_a)
  );
  lfsr5_checker #(.LOCK_COUNT(4), .LOSS_COUNT(8), .ERR_W(2)) u_dut_b (
    .clk (clk), .rst (rst), .chk_if (if_b)
  );

  typedef struct {
    int st;    // 0 hunting, 1 confirming, 2 locked
    int pred;
    int run;
    int miss;
    int err;
    int lk;
    int mm;
  } mdl_t;

  mdl_t ma;
  mdl_t mb;
  int   n_chk = 0;
  int   n_err = 0;

  function automatic int nxt(input int w);
    int fb;
    fb = (((w / 16) % 2) == ((w / 4) % 2)) ? 1 : 0;
    return ((w * 2) % 32) + fb;
  endfunction

  function automatic mdl_t step(input mdl_t m, input bit r, input bit v, input int w,
                                input bit clr, input int lock_n, input int loss_n,
                                input int err_max);
    mdl_t n;
    bit   bad;
    n   = m;
    bad = 1'b0;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    n.mm = 0;
    if (v) begin
      if (m.st == 0) begin
        if (w != 31) begin
          n.pred = nxt(w); n.run = 0; n.st = 1;
        end
      end else if (m.st == 1) begin
        if (w == m.pred) begin
          n.pred = nxt(m.pred); n.run = m.run + 1;
          if (n.run == lock_n) begin n.st = 2; n.miss = 0; end
        end else if (w != 31) begin
          n.pred = nxt(w); n.run = 0;
        end else begin
          n.st = 0;
        end
      end else begin
        n.pred = nxt(m.pred);
        if (w == m.pred && w != 31) begin
          n.miss = 0;
        end else begin
          bad = 1'b1; n.mm = 1; n.miss = m.miss + 1;
          if (!FLY || n.miss == loss_n) n.st = 0;
        end
      end
    end
    if (clr) n.err = 0;
    else if (bad && n.err < err_max) n.err = n.err + 1;
    n.lk = (n.st == 2) ? 1 : 0;
    return n;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input bit r, input bit v, input int w, input bit c);
    @(negedge clk);
    rst           = r;
    if_a.in_valid = v; if_a.in_word = LFSR_W'(w); if_a.clear = c;
    if_b.in_valid = v; if_b.in_word = LFSR_W'(w); if_b.clear = c;
    @(posedge clk);
    ma = step(ma, r, v, w, c, 4, 3, 255);
    mb = step(mb, r, v, w, c, 4, 8, 3);
    #1;
    check("a_locked",   int'(if_a.locked),    ma.lk);
    check("a_mismatch", int'(if_a.mismatch),  ma.mm);
    check("a_err",      int'(if_a.err_count), ma.err);
    check("b_locked",   int'(if_b.locked),    mb.lk);
    check("b_mismatch", int'(if_b.mismatch),  mb.mm);
    check("b_err",      int'(if_b.err_count), mb.err);
  endtask

  task automatic feed_from(input int start, input int n);
    int g;
    g = start;
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'b1, g, 1'b0);
      g = nxt(g);
    end
  endtask

  initial begin
    int g;
    int p;
    int seed0;
    ma = '{default: 0};
    mb = '{default: 0};
    seed0 = int'(SEED);

    // Lock from seed
    tick(1'b1, 1'b0, 0, 1'b0);
    tick(1'b1, 1'b0, 0, 1'b0);
    check("t0_reset_locked", int'(if_a.locked), 0);
    feed_from(seed0, 5);
    check("t1_locked", int'(if_a.locked), 1);
    check("t1_err", int'(if_a.err_count), 0);

    // Single error in place of 11001, then 10010
    tick(1'b0, 1'b1, 0, 1'b0);
    check("t2_pulse", int'(if_a.mismatch), 1);
    check("t2_err", int'(if_a.err_count), 1);
    check("t2_locked", int'(if_a.locked), FLY ? 1 : 0);
    tick(1'b0, 1'b1, 18, 1'b0);
    check("t2_no_pulse", int'(if_a.mismatch), 0);

    // Three consecutive wrong words while locked
    tick(1'b1, 1'b0, 0, 1'b0);
    feed_from(seed0, 8);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, ma.pred ^ 1, 1'b0);
    check("t3_locked", int'(if_a.locked), 0);
    check("t3_err", int'(if_a.err_count), FLY ? 3 : 1);

    // Lockup word in SEARCH, then a gap in VERIFY
    tick(1'b1, 1'b0, 0, 1'b0);
    tick(1'b0, 1'b1, 31, 1'b0);
    check("t4_lockup", int'(if_a.locked), 0);
    feed_from(seed0, 2);
    repeat (5) tick(1'b0, 1'b0, 31, 1'b0);
    feed_from(7, 3);
    check("t4_gap_lock", int'(if_a.locked), 1);

    // Clear coincident with a mismatch, then saturate the narrow counter
    p = ma.pred;
    tick(1'b0, 1'b1, p ^ 1, 1'b1);
    check("t5_clr_pulse", int'(if_a.mismatch), 1);
    check("t5_clr_err", int'(if_a.err_count), 0);
    g = nxt(p);
    for (int e = 0; e < 5; e++) begin
      for (int i = 0; i < 6; i++) begin
        tick(1'b0, 1'b1, g, 1'b0);
        g = nxt(g);
      end
      tick(1'b0, 1'b1, g ^ 1, 1'b0);
      g = nxt(g);
    end
    check("t5_sat", int'(if_b.err_count), 3);

    // Reset while locked, then relock takes LOCK_COUNT+1 words
    feed_from(g, 6);
    tick(1'b1, 1'b0, 0, 1'b0);
    check("t6_locked", int'(if_a.locked), 0);
    check("t6_err", int'(if_a.err_count), 0);
    feed_from(seed0, 4);
    check("t6_not_yet", int'(if_a.locked), 0);
    tick(1'b0, 1'b1, 28, 1'b0);
    check("t6_relock", int'(if_a.locked), 1);

    // Random stream with corruption, gaps, clears, reseeds and rare resets
    g = $urandom_range(0, 30);
    for (int c = 0; c < 1500; c++) begin
      bit r;
      bit v;
      bit clr;
      int w;
      r   = ($urandom_range(0, 299) == 0);
      v   = ($urandom_range(0, 5) != 0);
      clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 199) == 0) g = $urandom_range(0, 30);
      w = g;
      if ($urandom_range(0, 9) == 0) w = $urandom_range(0, 31);
      tick(r, v, w, clr);
      if (v) g = nxt(g);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
